// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported, variable-latency memory bus between instruction fetch and data access.
// MEM wins ties, stalls are raised until each access completes, and a watchdog aborts unacknowledged grants.
module mem_bus_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        if_ce_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   output logic        if_stallreq_o,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] mem_rdata_o,
   output logic        mem_stallreq_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   output logic        bus_err_o
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, BUS_MEM, BUS_IF} state_t;

   state_t           state;
   logic             done_if;
   logic             done_mem;
   logic [CNT_W-1:0] wd_cnt;
   logic             pend_if;
   logic             pend_mem;
   logic             advance;
   logic             wd_fire;

   assign pend_if        = if_ce_i & ~done_if;
   assign pend_mem       = mem_ce_i & ~done_mem;
   assign if_stallreq_o  = pend_if;
   assign mem_stallreq_o = pend_mem;
   assign advance        = ~pend_if & ~pend_mem;
   // The counter holds the number of unacknowledged grant cycles already seen,
   // so the abort fires in the TIMEOUT-th grant cycle.
   assign wd_fire        = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

   always_comb begin
      bus_req_o   = 1'b0;
      bus_we_o    = 1'b0;
      bus_sel_o   = 4'h0;
      bus_addr_o  = 32'h0;
      bus_wdata_o = 32'h0;
      case (state)
         BUS_MEM: begin
            bus_req_o   = 1'b1;
            bus_we_o    = mem_we_i;
            bus_sel_o   = mem_sel_i;
            bus_addr_o  = mem_addr_i;
            bus_wdata_o = mem_wdata_i;
         end
         BUS_IF: begin
            bus_req_o   = 1'b1;
            bus_sel_o   = 4'hF;
            bus_addr_o  = if_addr_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state       <= IDLE;
         done_if     <= 1'b0;
         done_mem    <= 1'b0;
         wd_cnt      <= '0;
         if_data_o   <= 32'h0;
         mem_rdata_o <= 32'h0;
         bus_err_o   <= 1'b0;
      end else begin
         bus_err_o <= 1'b0;
         // Completion below overrides this clear, so a flushed access that ends
         // in an advance cycle is still retired at the following one.
         if (advance) begin
            done_if  <= 1'b0;
            done_mem <= 1'b0;
         end
         case (state)
            IDLE: begin
               wd_cnt <= '0;
               if (pend_mem)     state <= BUS_MEM;
               else if (pend_if) state <= BUS_IF;
            end
            BUS_MEM: begin
               if (bus_ack_i) begin
                  mem_rdata_o <= mem_we_i ? 32'h0 : bus_rdata_i;
                  done_mem    <= 1'b1;
                  state       <= IDLE;
               end else if (wd_fire) begin
                  mem_rdata_o <= 32'h0;
                  done_mem    <= 1'b1;
                  bus_err_o   <= 1'b1;
                  state       <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            BUS_IF: begin
               if (bus_ack_i) begin
                  if_data_o <= bus_rdata_i;
                  done_if   <= 1'b1;
                  state     <= IDLE;
               end else if (wd_fire) begin
                  if_data_o <= 32'h0;
                  done_if   <= 1'b1;
                  bus_err_o <= 1'b1;
                  state     <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed accesses against a programmable-latency memory responder,
// with expected bus transactions and read data queued by the stimulus and checked by a monitor.
module tb_mem_bus_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        clr;
   logic        if_ce_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        if_stallreq_o;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [31:0] mem_rdata_o;
   logic        mem_stallreq_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        bus_err_o;

   mem_bus_arbiter #(.TIMEOUT(TO)) dut (
      .clk            (clk),
      .clr            (clr),
      .if_ce_i        (if_ce_i),
      .if_addr_i      (if_addr_i),
      .if_data_o      (if_data_o),
      .if_stallreq_o  (if_stallreq_o),
      .mem_ce_i       (mem_ce_i),
      .mem_we_i       (mem_we_i),
      .mem_sel_i      (mem_sel_i),
      .mem_addr_i     (mem_addr_i),
      .mem_wdata_i    (mem_wdata_i),
      .mem_rdata_o    (mem_rdata_o),
      .mem_stallreq_o (mem_stallreq_o),
      .bus_req_o      (bus_req_o),
      .bus_we_o       (bus_we_o),
      .bus_sel_o      (bus_sel_o),
      .bus_addr_o     (bus_addr_o),
      .bus_wdata_o    (bus_wdata_o),
      .bus_rdata_i    (bus_rdata_i),
      .bus_ack_i      (bus_ack_i),
      .bus_err_o      (bus_err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   bus_t        exp_bus[$];
   logic [31:0] exp_if[$];
   logic [31:0] exp_mem[$];
   int          total = 0;
   int          bad = 0;

   bit          ack_tie = 1'b0;
   bit          never_ack = 1'b0;
   int          wait_n = 0;
   logic [31:0] rd_val = 32'h0;

   bus_t        mon_obs;
   bus_t        mon_exp;
   logic [31:0] mon_d;

   function automatic bus_t mk(input logic err, input logic we, input logic [3:0] sel,
                               input logic [31:0] addr, input logic [31:0] wdata);
      bus_t b;
      b.err = err; b.we = we; b.sel = sel; b.addr = addr; b.wdata = wdata;
      return b;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endfunction

   // Memory responder: acks after wait_n grant cycles, or tied high, or never.
   initial begin : responder
      int gcnt;
      gcnt = 0;
      bus_ack_i = 1'b0;
      bus_rdata_i = 32'h0;
      forever begin
         @(negedge clk);
         if (ack_tie) begin
            bus_ack_i = 1'b1;
            bus_rdata_i = rd_val;
         end else if (bus_req_o) begin
            if (gcnt == wait_n && !never_ack) begin
               bus_ack_i = 1'b1;
               bus_rdata_i = rd_val;
            end else begin
               bus_ack_i = 1'b0;
               bus_rdata_i = 32'hA5A5A5A5;
            end
            gcnt++;
         end else begin
            bus_ack_i = 1'b0;
            gcnt = 0;
         end
      end
   end

   // Monitor: bus completions/aborts and requester data at each advance cycle.
   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         if ((bus_req_o && bus_ack_i) || bus_err_o) begin
            mon_obs = bus_err_o ? mk(1'b1, 1'b0, 4'h0, 32'h0, 32'h0)
                                : mk(1'b0, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o);
            total++;
            if (exp_bus.size() == 0) begin
               bad++;
               $display("FAIL bus_txn: got %h want none", mon_obs);
            end else begin
               mon_exp = exp_bus.pop_front();
               if (mon_obs !== mon_exp) begin
                  bad++;
                  $display("FAIL bus_txn: got %h want %h", mon_obs, mon_exp);
               end
            end
         end
         if (!if_stallreq_o && !mem_stallreq_o) begin
            if (if_ce_i) begin
               if (exp_if.size() == 0) begin
                  total++; bad++;
                  $display("FAIL if_data: got %h want none", if_data_o);
               end else begin
                  mon_d = exp_if.pop_front();
                  chk("if_data", if_data_o, mon_d);
               end
            end
            if (mem_ce_i) begin
               if (exp_mem.size() == 0) begin
                  total++; bad++;
                  $display("FAIL mem_rdata: got %h want none", mem_rdata_o);
               end else begin
                  mon_d = exp_mem.pop_front();
                  chk("mem_rdata", mem_rdata_o, mon_d);
               end
            end
         end
      end
   end

   // Call just after driving at a falling edge; samples until the advance cycle.
   task automatic run_adv(output int mem_lo, output int if_lo, output int req_n, output int err_n);
      bit done;
      mem_lo = -1; if_lo = -1; req_n = 0; err_n = 0; done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         if (k > 0) @(negedge clk);
         #2;
         if (mem_lo < 0 && !mem_stallreq_o) mem_lo = k;
         if (if_lo < 0 && !if_stallreq_o) if_lo = k;
         req_n += int'(bus_req_o);
         err_n += int'(bus_err_o);
         if (!mem_stallreq_o && !if_stallreq_o) done = 1'b1;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL advance_wait: got no advance in 40 cycles want advance");
      end
   endtask

   task automatic set_mem(input logic ce, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata);
      mem_ce_i = ce; mem_we_i = we; mem_sel_i = sel; mem_addr_i = addr; mem_wdata_i = wdata;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin : stim
      int mlo, ilo, rq, er;
      clr = 1'b1;
      if_ce_i = 1'b0;
      if_addr_i = 32'h0;
      set_mem(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // Reset with both requesting and the memory always acknowledging.
      idle(2);
      ack_tie = 1'b1;
      rd_val = 32'h11112222;
      if_ce_i = 1'b1;
      if_addr_i = 32'h104;
      set_mem(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
      @(negedge clk); #2;
      chk("rst_bus_req", {31'b0, bus_req_o}, 32'd0);
      chk("rst_bus_err", {31'b0, bus_err_o}, 32'd0);
      chk("rst_bus_addr", bus_addr_o, 32'h0);
      chk("rst_if_data", if_data_o, 32'h0);
      chk("rst_mem_rdata", mem_rdata_o, 32'h0);
      exp_bus.push_back(mk(1'b0, 1'b0, 4'hF, 32'h40, 32'h0));
      exp_bus.push_back(mk(1'b0, 1'b0, 4'hF, 32'h104, 32'h0));
      exp_mem.push_back(32'h11112222);
      exp_if.push_back(32'h11112222);
      @(negedge clk);
      clr = 1'b0;
      run_adv(mlo, ilo, rq, er);
      chk("rel_mem_lat", mlo, 2);
      chk("rel_if_lat", ilo, 4);
      @(negedge clk);
      if_ce_i = 1'b0;
      mem_ce_i = 1'b0;
      ack_tie = 1'b0;
      idle(2);

      // IF read with three wait cycles; the ack lands in the watchdog's last cycle.
      wait_n = 3;
      rd_val = 32'hDEADBEEF;
      exp_bus.push_back(mk(1'b0, 1'b0, 4'hF, 32'h100, 32'h0));
      exp_if.push_back(32'hDEADBEEF);
      @(negedge clk);
      if_ce_i = 1'b1;
      if_addr_i = 32'h100;
      run_adv(mlo, ilo, rq, er);
      chk("if_stall_cycles", ilo, 5);
      chk("if_grant_cycles", rq, 4);
      chk("if_ack_vs_to_err", er, 0);
      @(negedge clk);
      if_ce_i = 1'b0;
      idle(2);

      // Both pending: the MEM write goes on the bus before the IF read.
      wait_n = 0;
      rd_val = 32'hCAFEF00D;
      exp_bus.push_back(mk(1'b0, 1'b1, 4'b0011, 32'h2000, 32'h55AA));
      exp_bus.push_back(mk(1'b0, 1'b0, 4'hF, 32'h300, 32'h0));
      exp_mem.push_back(32'h0);
      exp_if.push_back(32'hCAFEF00D);
      @(negedge clk);
      if_ce_i = 1'b1;
      if_addr_i = 32'h300;
      set_mem(1'b1, 1'b1, 4'b0011, 32'h2000, 32'h55AA);
      run_adv(mlo, ilo, rq, er);
      chk("both_mem_lat", mlo, 2);
      chk("both_if_lat", ilo, 4);
      @(negedge clk);
      if_ce_i = 1'b0;
      set_mem(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle(2);

      // IF finishes first; its data must hold while MEM is still stalling.
      wait_n = 1;
      rd_val = 32'h12345678;
      exp_bus.push_back(mk(1'b0, 1'b0, 4'hF, 32'h400, 32'h0));
      exp_bus.push_back(mk(1'b0, 1'b0, 4'hF, 32'h500, 32'h0));
      exp_if.push_back(32'h12345678);
      exp_mem.push_back(32'h9ABCDEF0);
      @(negedge clk);
      if_ce_i = 1'b1;
      if_addr_i = 32'h400;
      @(negedge clk);
      set_mem(1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
      idle(2);
      rd_val = 32'h9ABCDEF0;
      @(negedge clk); #2;
      chk("hold_if_stall", {31'b0, if_stallreq_o}, 32'd0);
      chk("hold_mem_stall", {31'b0, mem_stallreq_o}, 32'd1);
      chk("hold_if_data", if_data_o, 32'h12345678);
      run_adv(mlo, ilo, rq, er);
      @(negedge clk);
      if_ce_i = 1'b0;
      set_mem(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle(2);

      // Watchdog abort of an unacknowledged MEM read.
      never_ack = 1'b1;
      exp_bus.push_back(mk(1'b1, 1'b0, 4'h0, 32'h0, 32'h0));
      exp_mem.push_back(32'h0);
      @(negedge clk);
      set_mem(1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
      run_adv(mlo, ilo, rq, er);
      chk("wd_grant_cycles", rq, 4);
      chk("wd_err_pulses", er, 1);
      chk("wd_mem_lat", mlo, 5);
      @(negedge clk);
      set_mem(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #2;
      chk("wd_idle_req", {31'b0, bus_req_o}, 32'd0);
      chk("wd_err_once", {31'b0, bus_err_o}, 32'd0);
      never_ack = 1'b0;
      idle(2);

      // MEM read acked in the same cycle the watchdog expires.
      wait_n = 3;
      rd_val = 32'h0BADF00D;
      exp_bus.push_back(mk(1'b0, 1'b0, 4'hF, 32'h700, 32'h0));
      exp_mem.push_back(32'h0BADF00D);
      @(negedge clk);
      set_mem(1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
      run_adv(mlo, ilo, rq, er);
      chk("tie_mem_lat", mlo, 5);
      chk("tie_no_err", er, 0);
      @(negedge clk);
      set_mem(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle(2);

      // Reset pulsed during a MEM grant, then the access is granted again from IDLE.
      never_ack = 1'b1;
      @(negedge clk);
      set_mem(1'b1, 1'b0, 4'hF, 32'h800, 32'h0);
      @(negedge clk); #2;
      chk("clr_pre_req", {31'b0, bus_req_o}, 32'd1);
      #1;
      clr = 1'b1;
      #1;
      chk("clr_drop_req", {31'b0, bus_req_o}, 32'd0);
      chk("clr_mem_rdata", mem_rdata_o, 32'h0);
      @(negedge clk);
      clr = 1'b0;
      never_ack = 1'b0;
      wait_n = 0;
      rd_val = 32'h13572468;
      exp_bus.push_back(mk(1'b0, 1'b0, 4'hF, 32'h800, 32'h0));
      exp_mem.push_back(32'h13572468);
      run_adv(mlo, ilo, rq, er);
      chk("regrant_mem_lat", mlo, 2);
      chk("regrant_cycles", rq, 1);
      @(negedge clk);
      set_mem(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle(4);

      chk("bus_q_left", exp_bus.size(), 0);
      chk("if_q_left", exp_if.size(), 0);
      chk("mem_q_left", exp_mem.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
